div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter SHIFT_WIDTH, default 8, number of fractional bits, range 0..31; the inverse of the right shift applied by the multiplier units.
REQ-002 SHALL have parameter APPROX_BITS, default 8, number of low quotient bits skipped when approximation is compiled in.
REQ-003 SHALL have port clk, input, 1, single clock; all logic on rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1, operand pair valid.
REQ-006 SHALL have port in_ready, output, 1, block accepts operands.
REQ-007 SHALL have port in_0, input, 32, signed dividend, two's complement.
REQ-008 SHALL have port in_1, input, 32, signed divisor, two's complement.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-011 SHALL have port out, output, 32, signed quotient.
REQ-012 SHALL have port div_zero, output, 1, result came from a zero divisor; qualified by out_valid.
REQ-013 SHALL have port busy, output, 1, high in RUN or DONE.

Function
REQ-014 SHALL compute out = trunc_toward_zero((in_0 * 2^SHIFT_WIDTH) / in_1), using a magnitude dividend of 32+SHIFT_WIDTH bits.
REQ-015 SHALL use an FSM with states IDLE, RUN and DONE; in_ready is high only in IDLE.
REQ-016 SHALL capture operands and signs, and move IDLE->RUN, on an edge where in_valid and in_ready are both high.
REQ-017 SHALL run a radix-2 restoring division in RUN, producing one quotient bit per cycle, MSB first, for N = 32+SHIFT_WIDTH cycles, then move RUN->DONE.
REQ-018 SHALL assert out_valid exactly N+1 rising edges after the accept edge.
REQ-019 SHALL negate the quotient magnitude when the operand signs differ.
REQ-020 SHALL saturate the result: magnitude above 2^31-1 with a positive result gives 0x7FFFFFFF; magnitude above 2^31 with a negative result gives 0x80000000.
REQ-021 SHALL, when in_1 == 0, skip RUN: go IDLE->DONE in one cycle with div_zero=1 and out = 0x80000000 if in_0 is negative, else 0x7FFFFFFF.
REQ-022 SHALL hold out, div_zero and out_valid stable in DONE until out_ready is sampled high, then move DONE->IDLE.
REQ-023 SHALL allow a new accept no earlier than the cycle after the result handshake; there is no overlap of operations.
REQ-024 SHALL ignore in_valid, in_0 and in_1 outside IDLE.

Reset
REQ-025 SHALL, on rst_n low at any time (including mid-RUN), go to IDLE, discard the operation, and set out=0, out_valid=0, div_zero=0, busy=0, in_ready=0.
REQ-026 SHALL raise in_ready on the first clock edge after rst_n deasserts.

Configuration
REQ-027 SHALL provide macro ARF_APPROX_DIV_EN; when defined, RUN lasts N-APPROX_BITS cycles, the low APPROX_BITS quotient bits are 0, and out_valid rises N-APPROX_BITS+1 edges after accept.
REQ-028 SHALL, when ARF_APPROX_DIV_EN is undefined, implement the exact behaviour of REQ-017 and REQ-018.

Structure
REQ-029 SHALL take SHIFT_WIDTH default, APPROX_BITS default and the IDLE/RUN/DONE state encoding from shared package arf_pkg.
REQ-030 SHALL put one restoring step (trial subtract, select, quotient bit) in combinational sub-module div_step, instantiated once.

Verification
All scenarios use SHIFT_WIDTH=8 (N=40) with exact mode unless stated.
REQ-031 SHALL cover: in_0=0x00000300, in_1=0x00000200 -> out=0x00000180, div_zero=0, out_valid 41 edges after accept.
REQ-032 SHALL cover: in_0=0xFFFFFD00, in_1=0x00000200 -> out=0xFFFFFE80; and in_0=0x00000100, in_1=0x00000300 -> out=0x00000055.
REQ-033 SHALL cover: in_0=0x00000005, in_1=0 -> out=0x7FFFFFFF, div_zero=1, out_valid 2 edges after accept; and in_0=0xFFFFFFFB, in_1=0 -> out=0x80000000.
REQ-034 SHALL cover: in_0=0x7FFFFFFF, in_1=0x00000001 -> out=0x7FFFFFFF (saturated); and in_0=0x80000000, in_1=0x00000100 -> out=0x80000000.
REQ-035 SHALL cover: out_ready held low 10 cycles in DONE -> out/out_valid stable, in_ready=0, and in_valid pulses ignored; the next accept occurs after the handshake.
REQ-036 SHALL cover: rst_n pulsed low at RUN cycle 20 -> all outputs reset, in_ready=1 after release; with ARF_APPROX_DIV_EN, 0x300/0x200 -> 0x00000100 after 33 edges.

Source files
------------

// File: rtl/arf_pkg.sv
// Shared constants, state encoding and saturation helper for the arithmetic block family.
package arf_pkg;

  localparam int unsigned ARF_DATA_W      = 32;
  localparam int unsigned ARF_SHIFT_WIDTH = 8;
  localparam int unsigned ARF_APPROX_BITS = 8;
  localparam int unsigned ARF_CNT_W       = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Largest representable result carrying the given sign.
  function automatic logic [ARF_DATA_W-1:0] sat_limit(input logic neg);
    return neg ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring division step: shift in a dividend bit, trial subtract, keep or restore.
module div_step
  import arf_pkg::*;
(
  input  logic [ARF_DATA_W-1:0] rem,
  input  logic                  dvd_bit,
  input  logic [ARF_DATA_W-1:0] dvs,
  output logic [ARF_DATA_W-1:0] rem_nxt_c,
  output logic                  q_bit_c
);

  logic [ARF_DATA_W:0] shifted;
  logic [ARF_DATA_W:0] trial;

  // Remainder stays below the divisor, so 33 bits hold the shifted value and the borrow.
  always_comb begin
    shifted   = {rem, dvd_bit};
    trial     = shifted - {1'b0, dvs};
    q_bit_c   = ~trial[ARF_DATA_W];
    rem_nxt_c = q_bit_c ? trial[ARF_DATA_W-1:0] : shifted[ARF_DATA_W-1:0];
  end

endmodule

// File: rtl/div_seq.sv
// Sequential signed fixed-point divider: out = trunc((in_0 << SHIFT_WIDTH) / in_1), saturated.
// Define ARF_APPROX_DIV_EN to skip the low APPROX_BITS quotient bits for a shorter run.
module div_seq
  import arf_pkg::*;
#(
  parameter int unsigned SHIFT_WIDTH = ARF_SHIFT_WIDTH,
  parameter int unsigned APPROX_BITS = ARF_APPROX_BITS
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_0,
  input  logic [31:0] in_1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out,
  output logic        div_zero,
  output logic        busy
);

  localparam int unsigned N = ARF_DATA_W + SHIFT_WIDTH;
`ifdef ARF_APPROX_DIV_EN
  localparam bit APPROX_EN = 1'b1;
`else
  localparam bit APPROX_EN = 1'b0;
`endif
  localparam int unsigned SKIP  = APPROX_EN ? APPROX_BITS : 0;
  localparam int unsigned STEPS = N - SKIP;

  div_state_e            state;
  logic [ARF_CNT_W-1:0]  cnt;
  logic [N-1:0]          dvd;
  logic [N-1:0]          quot;
  logic [N-1:0]          quot_full;
  logic [ARF_DATA_W-1:0] dvs;
  logic [ARF_DATA_W-1:0] rem;
  logic [ARF_DATA_W-1:0] rem_nxt;
  logic                  q_bit;
  logic                  a_neg;
  logic                  res_neg;
  logic                  dvs_zero;
  logic [ARF_DATA_W-1:0] mag_a;
  logic [ARF_DATA_W-1:0] mag_b;
  logic [ARF_DATA_W-1:0] res;

  // Operand magnitudes; 0x80000000 maps to 2^31, which still fits unsigned.
  always_comb begin
    mag_a = in_0[31] ? 32'(-in_0) : in_0;
    mag_b = in_1[31] ? 32'(-in_1) : in_1;
  end

  div_step u_div_step (
    .rem       (rem),
    .dvd_bit   (dvd[N-1]),
    .dvs       (dvs),
    .rem_nxt_c (rem_nxt),
    .q_bit_c   (q_bit)
  );

  // Skipped low bits (approximate mode) read as zero; sign applied after saturation check.
  always_comb begin
    quot_full = quot << SKIP;
    res       = quot_full[ARF_DATA_W-1:0];
    if (dvs_zero) begin
      res = sat_limit(a_neg);
    end else if (!res_neg && (quot_full > N'(32'h7FFF_FFFF))) begin
      res = sat_limit(1'b0);
    end else if (res_neg && (quot_full > N'(32'h8000_0000))) begin
      res = sat_limit(1'b1);
    end else if (res_neg) begin
      res = 32'(-quot_full[ARF_DATA_W-1:0]);
    end
  end

  // Control FSM and datapath registers; result is latched on the first DONE cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      dvd       <= '0;
      quot      <= '0;
      dvs       <= '0;
      rem       <= '0;
      a_neg     <= 1'b0;
      res_neg   <= 1'b0;
      dvs_zero  <= 1'b0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out       <= '0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            dvd      <= N'(mag_a) << SHIFT_WIDTH;
            dvs      <= mag_b;
            rem      <= '0;
            quot     <= '0;
            cnt      <= '0;
            a_neg    <= in_0[31];
            res_neg  <= in_0[31] ^ in_1[31];
            dvs_zero <= (in_1 == '0);
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A zero divisor spends a single cycle here without stepping.
          if (!dvs_zero) begin
            dvd  <= dvd << 1;
            rem  <= rem_nxt;
            quot <= {quot[N-2:0], q_bit};
          end
          cnt <= cnt + ARF_CNT_W'(1);
          if (dvs_zero || (cnt == ARF_CNT_W'(STEPS - 1))) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!out_valid) begin
            out       <= res;
            div_zero  <= dvs_zero;
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            div_zero  <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: expected quotients from a behavioural model, latency and handshake checks.
module tb_div_seq;

  localparam int SW = 8;
  localparam int AB = 8;
  localparam int N  = 32 + SW;
`ifdef ARF_APPROX_DIV_EN
  localparam int SKIP = AB;
`else
  localparam int SKIP = 0;
`endif
  localparam int LAT      = N - SKIP + 1;
  localparam int LAT_ZERO = 2;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_0      = '0;
  logic [31:0] in_1      = '0;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out;
  logic        div_zero;
  logic        busy;

  always #5 clk = ~clk;

  div_seq #(
    .SHIFT_WIDTH (SW),
    .APPROX_BITS (AB)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_0      (in_0),
    .in_1      (in_1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .div_zero  (div_zero),
    .busy      (busy)
  );

  typedef struct {
    logic [31:0] q;
    logic        dz;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb_v;
    longint num;
    longint mag;
    bit     neg;
    sa   = longint'($signed(a));
    sb_v = longint'($signed(b));
    if (b == 32'h0) begin
      e.q   = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
      e.dz  = 1'b1;
      e.lat = LAT_ZERO;
    end else begin
      num = sa * (longint'(1) << SW);
      if (num < 0) num = -num;
      if (sb_v < 0) sb_v = -sb_v;
      mag = num / sb_v;
      mag = mag & ~((longint'(1) << SKIP) - 1);
      neg = ($signed(a) < 0) != ($signed(b) < 0);
      if (!neg && mag > 64'h7FFF_FFFF)      e.q = 32'h7FFF_FFFF;
      else if (neg && mag > 64'h8000_0000)  e.q = 32'h8000_0000;
      else if (neg)                          e.q = 32'(-mag);
      else                                   e.q = 32'(mag);
      e.dz  = 1'b0;
      e.lat = LAT;
    end
    return e;
  endfunction

  task automatic wait_ready();
    int c = 0;
    while (!in_ready && c < 100) begin
      @(posedge clk);
      #1;
      c++;
    end
    check("in_ready_wait", in_ready, 1'b1);
  endtask

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    wait_ready();
    @(negedge clk);
    in_valid = 1'b1;
    in_0     = a;
    in_1     = b;
    check("in_ready_at_accept", in_ready, 1'b1);
    @(posedge clk);
    sb.push_back(model(a, b));
    #1;
    in_valid = 1'b0;
    in_0     = $urandom;
    in_1     = $urandom;
    check("busy_after_accept", busy, 1'b1);
    check("in_ready_after_accept", in_ready, 1'b0);
  endtask

  task automatic finish_op(input int hold);
    int          lat = 0;
    exp_t        e;
    logic [31:0] held;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (sb.size() == 0) begin
      check("scoreboard_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    check("latency", 64'(lat), 64'(e.lat));
    check("out", out, e.q);
    check("div_zero", div_zero, e.dz);
    held = out;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = i[0];
      in_0     = $urandom;
      in_1     = $urandom;
      @(posedge clk);
      #1;
      check("hold_out", out, held);
      check("hold_valid", out_valid, 1'b1);
      check("hold_in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("valid_after_handshake", out_valid, 1'b0);
    check("ready_after_handshake", in_ready, 1'b1);
    check("busy_after_handshake", busy, 1'b0);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  logic [31:0] va [8] = '{32'h0000_0300, 32'hFFFF_FD00, 32'h0000_0100, 32'h0000_0005,
                          32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_F000};
  logic [31:0] vb [8] = '{32'h0000_0200, 32'h0000_0200, 32'h0000_0300, 32'h0000_0000,
                          32'h0000_0000, 32'h0000_0001, 32'h0000_0100, 32'hFFFF_FFFD};

  initial begin
    #500us;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", out, 32'h0);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_div_zero", div_zero, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", in_ready, 1'b1);

    for (int i = 0; i < 8; i++) begin
      start_op(va[i], vb[i]);
      finish_op(0);
    end

    // Result held against backpressure, then a fresh operation right after the handshake.
    start_op(32'h0000_0300, 32'h0000_0200);
    finish_op(10);
    start_op(32'h0000_0100, 32'h0000_0300);
    finish_op(0);

    for (int i = 0; i < 6; i++) begin
      logic [31:0] ra;
      logic [31:0] rb;
      ra = $urandom;
      rb = i[0] ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i == 2) ra = ra >> 12;
      start_op(ra, rb);
      finish_op(i % 3);
    end

    // Reset in the middle of a run discards the operation.
    start_op(32'h0000_0300, 32'h0000_0200);
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("midrun_rst_out", out, 32'h0);
    check("midrun_rst_valid", out_valid, 1'b0);
    check("midrun_rst_div_zero", div_zero, 1'b0);
    check("midrun_rst_busy", busy, 1'b0);
    check("midrun_rst_in_ready", in_ready, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrun_ready_after_release", in_ready, 1'b1);
    start_op(32'hFFFF_FD00, 32'h0000_0200);
    finish_op(0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
